// File: rtl/cnt_cmd_ctrl.sv
// Command sequencer for an up/down counter: accepts LOAD/UP/DOWN/NOP over
// valid/ready and drives load, load_en and down each cycle, holding the count between commands.
module cnt_cmd_ctrl #(
  parameter int WIDTH = 4,
  parameter int STEPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_val,
  input  logic [STEPW-1:0] cmd_steps,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt_load,
  output logic             cnt_load_en,
  output logic             cnt_down,
  input  logic [WIDTH-1:0] cnt_count,
  input  logic             cnt_rollover,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [STEPW-1:0] wrap_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  state_t           state, next_state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] val_q;
  logic [STEPW-1:0] remaining;
  logic             accept;
  logic             wrap_hit;

  assign accept   = cmd_valid && cmd_ready;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  // The step about to happen crosses the count boundary in the counting direction.
  assign wrap_hit = ((op_q == OP_UP) && cnt_rollover) ||
                    ((op_q == OP_DOWN) && (cnt_count == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    cmd_ready   = 1'b0;
    cnt_load_en = 1'b1;
    cnt_load    = cnt_count;
    cnt_down    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          case (cmd_op)
            OP_LOAD: next_state = LOAD;
            OP_UP, OP_DOWN: next_state = (cmd_steps != '0) ? RUN : DONE;
            default: next_state = DONE;
          endcase
        end
      end
      LOAD: begin
        cnt_load   = val_q;
        next_state = DONE;
      end
      RUN: begin
        if (abort) begin
          next_state = DONE;
        end else begin
          cnt_load_en = 1'b0;
          cnt_down    = (op_q == OP_DOWN);
          if (remaining == STEPW'(1)) next_state = DONE;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_LOAD;
      val_q     <= '0;
      remaining <= '0;
      wrap_cnt  <= '0;
      aborted   <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        op_q      <= cmd_op;
        val_q     <= cmd_val;
        remaining <= cmd_steps;
        wrap_cnt  <= '0;
        aborted   <= 1'b0;
      end
    end else if (state == RUN) begin
      if (abort) begin
        aborted <= 1'b1;
      end else begin
        remaining <= remaining - STEPW'(1);
        if (wrap_hit && (wrap_cnt != '1)) wrap_cnt <= wrap_cnt + STEPW'(1);
      end
    end
  end

endmodule
